iterative_alu: RTL and testbench

Execute-stage ALU that consumes the 4-bit `alufn` code from the ALU control decoder plus two operands, and returns a registered result with condition flags for the branch unit. Shifts run serially, one bit position per cycle, so that no barrel shifter is needed. Other operations complete in one cycle. Operands enter and results leave over valid/ready handshakes, so the pipeline stalls while a long shift is in progress.

---
 rtl/iterative_alu.sv | 141 ++++++++++++++
 tb/tb_iterative_alu.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Execute-stage ALU with valid/ready handshakes. Shifts move one bit per cycle,
// so no barrel shifter is needed; every other op completes in one cycle.
//   state | meaning
//   IDLE  | waiting for an operation
//   SHIFT | serial shift in progress, one bit position per cycle
//   DONE  | result and flags held until the consumer takes them
module iterative_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         alufn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zf,
  output logic               cf,
  output logic               vf,
  output logic               sf
);

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_SLTU = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         op;

  logic               accept;
  logic               is_sub;
  logic               is_shift;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res_now;
  logic               cf_now;
  logic               vf_now;
  logic [WIDTH-1:0]   shifted;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // SUB is formed as a + ~b + 1 so cf reads as "no borrow".
  always_comb begin
    is_sub   = (alufn == ALU_SUB);
    is_shift = (alufn == ALU_SLL) || (alufn == ALU_SRL) || (alufn == ALU_SRA);
    b_eff    = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    res_now  = '0;
    cf_now   = 1'b0;
    vf_now   = 1'b0;
    case (alufn)
      ALU_ADD, ALU_SUB: begin
        res_now = sum[WIDTH-1:0];
        cf_now  = sum[WIDTH];
        vf_now  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  res_now = a & b;
      ALU_OR:   res_now = a | b;
      ALU_XOR:  res_now = a ^ b;
      ALU_SLT:  res_now = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res_now = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL, ALU_SRL, ALU_SRA: res_now = a;
      default:  res_now = '0;
    endcase
  end

  always_comb begin
    case (op)
      ALU_SLL: shifted = {work[WIDTH-2:0], 1'b0};
      ALU_SRA: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shifted = {1'b0, work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      op        <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zf        <= 1'b0;
      cf        <= 1'b0;
      vf        <= 1'b0;
      sf        <= 1'b0;
    end else if (state == SHIFT) begin
      work <= shifted;
      cnt  <= cnt - 1'b1;
      if (cnt == SHAMT_W'(1)) begin
        result    <= shifted;
        zf        <= (shifted == '0);
        sf        <= shifted[WIDTH-1];
        cf        <= 1'b0;
        vf        <= 1'b0;
        out_valid <= 1'b1;
        state     <= DONE;
      end
    end else begin
      if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
        state     <= IDLE;
      end
      // A new op accepted in the same cycle overrides the return to IDLE.
      if (accept) begin
        op   <= alufn;
        work <= a;
        cnt  <= b[SHAMT_W-1:0];
        if (is_shift && (b[SHAMT_W-1:0] != '0)) begin
          out_valid <= 1'b0;
          state     <= SHIFT;
        end else begin
          result    <= res_now;
          zf        <= (res_now == '0);
          sf        <= res_now[WIDTH-1];
          cf        <= cf_now;
          vf        <= vf_now;
          out_valid <= 1'b1;
          state     <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed-vector bench for iterative_alu: hand-computed results, flags,
// latencies, backpressure and asynchronous reset during a shift.
module tb_iterative_alu;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_SLTU = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alufn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zf, cf, vf, sf;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;

  assign flags = {zf, cf, vf, sf};

  always #5 clk = ~clk;

  iterative_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alufn     (alufn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zf        (zf),
    .cf        (cf),
    .vf        (vf),
    .sf        (sf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags expected as {zf, cf, vf, sf}; inputs are scrambled after acceptance
  task automatic expect_op(input string tag, input logic [3:0] fn, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_res,
                           input logic [3:0] exp_flags, input int exp_lat);
    int lat;
    logic rdy_seen;
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    alufn = fn; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; alufn = ALU_XOR; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_ready"}, {31'b0, rdy_seen}, 32'd0);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " flags"}, {28'b0, flags}, {28'b0, exp_flags});
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alufn = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst flags", {28'b0, flags}, 32'd0);
    rst_n = 1'b1;
    tick();

    expect_op("add_ovf",  ALU_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0011, 1);
    expect_op("sub_eq",   ALU_SUB,  32'd5,         32'd5,         32'h0,         4'b1100, 1);
    expect_op("sub_brw",  ALU_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 4'b0001, 1);
    expect_op("sltu",     ALU_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1,         4'b0000, 1);
    expect_op("slt",      ALU_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0,         4'b1000, 1);
    expect_op("sra31",    ALU_SRA,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 4'b0001, 32);
    expect_op("sll0",     ALU_SLL,  32'h1234_5678, 32'd0,         32'h1234_5678, 4'b0000, 1);
    expect_op("and",      ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0001, 1);
    expect_op("or",       ALU_OR,   32'h0F0F_0000, 32'h00F0_000F, 32'h0FFF_000F, 4'b0000, 1);
    expect_op("xor",      ALU_XOR,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,         4'b1000, 1);
    expect_op("add_cry",  ALU_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1100, 1);
    expect_op("sub_ovf",  ALU_SUB,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0110, 1);
    expect_op("sll4",     ALU_SLL,  32'h1,         32'd4,         32'h10,        4'b0000, 5);
    expect_op("srl20",    ALU_SRL,  32'h8000_0000, 32'd20,        32'h800,       4'b0000, 21);
    expect_op("sll_hib",  ALU_SLL,  32'h1,         32'h25,        32'h20,        4'b0000, 6);
    expect_op("sra_pos",  ALU_SRA,  32'h4000_0000, 32'd2,         32'h1000_0000, 4'b0000, 3);
    expect_op("illegal",  4'hF,     32'h1234_5678, 32'h1,         32'h0,         4'b1000, 1);

    // back-to-back: second op accepted in the cycle the first result is taken
    alufn = ALU_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    tick();
    chk("b2b first valid", {31'b0, out_valid}, 32'd1);
    chk("b2b first result", result, 32'd3);
    chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
    alufn = ALU_SUB; a = 32'd10; b = 32'd4;
    tick();
    in_valid = 1'b0;
    chk("b2b second valid", {31'b0, out_valid}, 32'd1);
    chk("b2b second result", result, 32'd6);
    tick();
    chk("b2b drained", {31'b0, out_valid}, 32'd0);

    // backpressure: result held, nothing new accepted
    out_ready = 1'b0;
    alufn = ALU_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    tick();
    a = 32'd100; b = 32'd100;
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", {31'b0, out_valid}, 32'd1);
      chk("bp result", result, 32'd7);
      chk("bp flags", {28'b0, flags}, 32'd0);
      chk("bp in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp released", {31'b0, out_valid}, 32'd0);

    // reset in the middle of a 20-bit SRL
    alufn = ALU_SRL; a = 32'hFFFF_0000; b = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("shift busy", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst result", result, 32'd0);
    chk("mid rst flags", {28'b0, flags}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
    chk("aborted no output", {31'b0, out_valid}, 32'd0);
    expect_op("add_after_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
